// File: rtl/instr_fetch_unit.sv
// Fetch stage: registered instruction memory read feeding a small output buffer; one-cycle read latency.
// Stall is raised when the buffer plus any in-flight read would exceed BUF_DEPTH; a branch flushes everything.
module instr_fetch_unit #(
    parameter int AW        = 10,
    parameter int DW        = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] instr_address,
    input  logic          fetch_en,
    input  logic          branch,
    output logic          stall,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int OW = CW + 1;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_pc;
    logic          inflight;

    logic [DW-1:0] buf_data [BUF_DEPTH];
    logic [AW-1:0] buf_pc   [BUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          push;
    logic          issue;
    logic [OW-1:0] occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign instr_valid = (count != '0);
    assign pop         = instr_valid & instr_ready;
    // The in-flight read already owns a slot, so it counts toward occupancy.
    assign occupancy   = OW'(count) + OW'(inflight) - OW'(pop);
    assign stall       = (occupancy >= OW'(BUF_DEPTH));
    assign issue       = fetch_en & ~stall & ~branch;
    assign push        = inflight & ~branch;
    assign instr       = buf_data[rd_ptr];
    assign instr_pc    = buf_pc[rd_ptr];

    // Memory is never reset; a same-address write and read returns the old word.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
        if (issue) begin
            rd_data <= mem[instr_address];
            rd_pc   <= instr_address;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (branch) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= rd_data;
                buf_pc[wr_ptr]   <= rd_pc;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a behavioural queue model tracks every issued fetch and is compared at each pop,
// while scenario tasks check specific cycle-level behaviour inline.
module tb_instr_fetch_unit;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int BD = 2;
    localparam int EW = AW + DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] instr_address = '0;
    logic          fetch_en = 1'b0;
    logic          branch = 1'b0;
    logic          stall;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_data = '0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem_m [1 << AW];
    logic [EW-1:0] q [$];
    logic [EW-1:0] pend_e;
    int            pend = 0;
    int            m_pop;
    int            m_occ;
    logic          m_valid;
    logic          m_stall;
    logic          m_issue;

    instr_fetch_unit #(.AW(AW), .DW(DW), .BUF_DEPTH(BD)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_address (instr_address),
        .fetch_en      (fetch_en),
        .branch        (branch),
        .stall         (stall),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data)
    );

    always #5 clk = ~clk;

    // Scoreboard: entries pushed when a fetch is accepted, popped and compared when decode consumes one.
    always @(negedge clk) begin
        #3;
        if (!reset) begin
            q.delete();
            pend = 0;
        end else begin
            m_valid = (q.size() != 0);
            m_pop   = (m_valid && instr_ready) ? 1 : 0;
            m_occ   = q.size() + pend - m_pop;
            m_stall = (m_occ >= BD);
            checks++;
            if (instr_valid !== m_valid) begin
                errors++;
                $display("FAIL sb_valid t=%0t: got %0b want %0b", $time, instr_valid, m_valid);
            end
            checks++;
            if (stall !== m_stall) begin
                errors++;
                $display("FAIL sb_stall t=%0t: got %0b want %0b", $time, stall, m_stall);
            end
            if (m_pop != 0) begin
                checks++;
                if ({instr_pc, instr} !== q[0]) begin
                    errors++;
                    $display("FAIL sb_entry t=%0t: got pc=%h instr=%h want pc=%h instr=%h",
                             $time, instr_pc, instr, q[0][EW-1:DW], q[0][DW-1:0]);
                end
            end
            m_issue = fetch_en && !m_stall && !branch;
            if (branch) begin
                q.delete();
                pend = 0;
            end else begin
                if (m_pop != 0) void'(q.pop_front());
                if (pend != 0) q.push_back(pend_e);
            end
            pend = m_issue ? 1 : 0;
            if (m_issue) pend_e = {instr_address, mem_m[instr_address]};
            if (prog_we) mem_m[prog_addr] = prog_data;
        end
    end

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", instr_valid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b want 0", stall); end
        checks++; if (instr !== '0) begin errors++; $display("FAIL rst_instr: got %h want 0", instr); end
        checks++; if (instr_pc !== '0) begin errors++; $display("FAIL rst_pc: got %h want 0", instr_pc); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_load();
        logic [DW-1:0] d;
        for (int a = 0; a < (1 << AW); a++) begin
            @(negedge clk);
            if (a < 4) d = DW'(16'h1111 * (a + 1));
            else if (a == (1 << AW) - 1) d = 16'hBEEF;
            else d = DW'(a);
            prog_we   = 1'b1;
            prog_addr = AW'(a);
            prog_data = d;
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic test_stream();
        logic [DW-1:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            fetch_en = 1'b1; instr_ready = 1'b1; instr_address = AW'(i);
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stream_stall i=%0d: got %0b want 0", i, stall); end
            if (i >= 2) begin
                exp_d = DW'(16'h1111 * (i - 1));
                checks++;
                if (instr_valid !== 1'b1 || instr !== exp_d) begin
                    errors++;
                    $display("FAIL stream_instr i=%0d: got v=%0b %h want v=1 %h", i, instr_valid, instr, exp_d);
                end
            end
        end
        @(negedge clk);
        fetch_en = 1'b0; instr_address = 'x;
        #1;
        checks++; if (instr !== 16'h3333) begin errors++; $display("FAIL stream_tail3: got %h want 3333", instr); end
        @(negedge clk); #1;
        checks++; if (instr !== 16'h4444) begin errors++; $display("FAIL stream_tail4: got %h want 4444", instr); end
        @(negedge clk); #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %0b want 0", instr_valid); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        instr_ready = 1'b0; fetch_en = 1'b1; instr_address = 10'd0;
        @(negedge clk);
        instr_address = 10'd1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bp_stall_early: got %0b want 0", stall); end
        @(negedge clk);
        instr_address = 10'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (stall !== 1'b1 || instr !== 16'h1111) begin
                errors++;
                $display("FAIL bp_hold k=%0d: got stall=%0b %h want stall=1 1111", k, stall, instr);
            end
            @(negedge clk);
        end
        instr_ready = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bp_release: got %0b want 0", stall); end
        @(negedge clk);
        fetch_en = 1'b0;
        #1;
        checks++; if (instr !== 16'h2222) begin errors++; $display("FAIL bp_second: got %h want 2222", instr); end
        @(negedge clk); #1;
        checks++; if (instr !== 16'h3333) begin errors++; $display("FAIL bp_third: got %h want 3333", instr); end
        @(negedge clk); #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b want 0", instr_valid); end
    endtask

    task automatic test_branch();
        @(negedge clk);
        instr_ready = 1'b0; fetch_en = 1'b1; instr_address = 10'd0;
        @(negedge clk);
        instr_address = 10'd1;
        @(negedge clk);
        branch = 1'b1; instr_address = 10'h200;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_pre_stall: got %0b want 1", stall); end
        @(negedge clk);
        branch = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL br_flushed: got %0b want 0", instr_valid); end
        @(negedge clk);
        fetch_en = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL br_no_stale: got %0b want 0", instr_valid); end
        @(negedge clk); #1;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 10'h200 || instr !== 16'h0200) begin
            errors++;
            $display("FAIL br_target: got v=%0b pc=%h %h want v=1 pc=200 0200", instr_valid, instr_pc, instr);
        end
        instr_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL br_drain: got %0b want 0", instr_valid); end
    endtask

    task automatic test_same_cycle_write();
        @(negedge clk);
        instr_ready = 1'b1; fetch_en = 1'b1; instr_address = 10'd5;
        prog_we = 1'b1; prog_addr = 10'd5; prog_data = 16'hABCD;
        @(negedge clk);
        prog_we = 1'b0;
        @(negedge clk);
        fetch_en = 1'b0;
        #1;
        checks++; if (instr !== 16'h0005 || instr_pc !== 10'd5) begin errors++; $display("FAIL wr_old: got pc=%h %h want pc=005 0005", instr_pc, instr); end
        @(negedge clk); #1;
        checks++; if (instr !== 16'hABCD) begin errors++; $display("FAIL wr_new: got %h want abcd", instr); end
        @(negedge clk); #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wr_empty: got %0b want 0", instr_valid); end
    endtask

    task automatic test_addr_wrap();
        @(negedge clk);
        instr_ready = 1'b1; fetch_en = 1'b1; instr_address = 10'h3FF;
        @(negedge clk);
        instr_address = 10'h000;
        @(negedge clk);
        fetch_en = 1'b0;
        #1;
        checks++; if (instr_pc !== 10'h3FF || instr !== 16'hBEEF) begin errors++; $display("FAIL wrap_top: got pc=%h %h want pc=3ff beef", instr_pc, instr); end
        @(negedge clk); #1;
        checks++; if (instr_pc !== 10'h000 || instr !== 16'h1111) begin errors++; $display("FAIL wrap_zero: got pc=%h %h want pc=000 1111", instr_pc, instr); end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        instr_ready = 1'b0; fetch_en = 1'b1; instr_address = 10'd0;
        @(negedge clk);
        instr_address = 10'd1;
        @(negedge clk);
        instr_address = 10'd2;
        #1;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill: got %0b want 1", instr_valid); end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || stall !== 1'b0 || instr !== '0 || instr_pc !== '0) begin
            errors++;
            $display("FAIL mid_async_clear: got v=%0b s=%0b pc=%h %h want all 0", instr_valid, stall, instr_pc, instr);
        end
        @(negedge clk);
        reset = 1'b1; instr_ready = 1'b1; fetch_en = 1'b1; instr_address = 10'd3;
        #1;
        checks++; if (stall !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_release: got s=%0b v=%0b want 0 0", stall, instr_valid); end
        @(negedge clk);
        fetch_en = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %0b want 0", instr_valid); end
        @(negedge clk); #1;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 10'd3 || instr !== 16'h4444) begin
            errors++;
            $display("FAIL mid_first_fetch: got v=%0b pc=%h %h want v=1 pc=003 4444", instr_valid, instr_pc, instr);
        end
        @(negedge clk); #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_empty: got %0b want 0", instr_valid); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stream();
        test_backpressure();
        test_branch();
        test_same_cycle_write();
        test_addr_wrap();
        test_reset_midop();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
